// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: request/grant/response bus handshake, byte lanes, load alignment.
// Optional MEM_MISALIGN_CHECK_EN: trap misaligned half/word accesses without touching the bus.
module mem_access_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_size_i,
  input  logic        req_sign_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  addr_lo;
  logic [2:0]  size;
  logic        sign;
  logic        write;

  // Byte offset actually honoured: half uses only a[1], word ignores the offset.
  function automatic logic [1:0] eff_off(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'b000:  eff_off = a;
      3'b001:  eff_off = {a[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'b000:  byte_en = 4'b0001 << eff_off(sz, a);
      3'b001:  byte_en = 4'b0011 << eff_off(sz, a);
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] sz, input logic [31:0] wd);
    case (sz)
      3'b000:  store_data = {4{wd[7:0]}};
      3'b001:  store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input logic [2:0] sz, input logic sg,
                                            input logic [1:0] a, input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {eff_off(sz, a), 3'b000};
    case (sz)
      3'b000:  load_data = {{24{sg & shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{sg & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'b000:  is_misaligned = 1'b0;
      3'b001:  is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction
`endif

  // Combinational so the pipeline freezes in the very cycle the access is presented.
  assign stall_o = ((state == IDLE) && req_valid_i) || (state == REQ) || (state == WAIT);

  // Sequencer state, latched request fields and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      addr_lo     <= 2'b00;
      size        <= 3'b000;
      sign        <= 1'b0;
      write       <= 1'b0;
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
      rdata_o     <= 32'h0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= 32'h0;
    end else begin
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_lo <= req_addr_i[1:0];
            size    <= req_size_i;
            sign    <= req_sign_i;
            write   <= req_write_i;
`ifdef MEM_MISALIGN_CHECK_EN
            if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
              state      <= DONE;
              done_o     <= 1'b1;
              misalign_o <= 1'b1;
            end else
`endif
            begin
              state       <= REQ;
              bus_req_o   <= 1'b1;
              bus_we_o    <= req_write_i;
              bus_addr_o  <= {req_addr_i[31:2], 2'b00};
              bus_be_o    <= byte_en(req_size_i, req_addr_i[1:0]);
              bus_wdata_o <= store_data(req_size_i, req_wdata_i);
            end
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            if (write) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else if (bus_rvalid_i) begin
              state   <= DONE;
              done_o  <= 1'b1;
              rdata_o <= load_data(size, sign, addr_lo, bus_rdata_i);
            end else begin
              state <= WAIT;
            end
          end else begin
            state <= REQ;
          end
        end
        WAIT: begin
          if (bus_rvalid_i) begin
            state   <= DONE;
            done_o  <= 1'b1;
            rdata_o <= load_data(size, sign, addr_lo, bus_rdata_i);
          end else begin
            state <= WAIT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver models MEM stage and bus, monitor checks at negedge.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        req_sign;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  mem_access_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_size_i  (req_size),
    .req_sign_i  (req_sign),
    .stall_o     (stall),
    .done_o      (done),
    .rdata_o     (rdata),
    .misalign_o  (misalign),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_be_o    (bus_be),
    .bus_wdata_o (bus_wdata),
    .bus_gnt_i   (bus_gnt),
    .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    int          stall_cnt = 0;
    logic        in_req = 1'b0;
    logic        req_seen = 1'b0;
    logic        s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
        in_req    = 1'b0;
        req_seen  = 1'b0;
      end else begin
        if (stall) stall_cnt++;
        if (bus_req) begin
          req_seen = 1'b1;
          if (!in_req) begin
            s_we = bus_we; s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata;
            if (sb.size() > 0) begin
              check_eq("bus_we", {31'h0, bus_we}, {31'h0, sb[0].we});
              check_eq("bus_addr", bus_addr, sb[0].addr);
              check_eq("bus_be", {28'h0, bus_be}, {28'h0, sb[0].be});
              check_eq("bus_wdata", bus_wdata, sb[0].wdata);
            end
          end else begin
            check_eq("stable_we", {31'h0, bus_we}, {31'h0, s_we});
            check_eq("stable_addr", bus_addr, s_addr);
            check_eq("stable_be", {28'h0, bus_be}, {28'h0, s_be});
            check_eq("stable_wdata", bus_wdata, s_wdata);
          end
          check_eq("stall_in_req", {31'h0, stall}, 32'h1);
          in_req = 1'b1;
        end else begin
          in_req = 1'b0;
        end
        if (done) begin
          if (sb.size() == 0) begin
            check_eq("spurious_done", 32'h1, 32'h0);
          end else begin
            e = sb.pop_front();
            check_eq("rdata", rdata, e.rdata);
            check_eq("stall_cycles", stall_cnt, e.stall);
            check_eq("misalign", {31'h0, misalign}, {31'h0, e.mis});
            check_eq("bus_used", {31'h0, req_seen}, {31'h0, ~e.mis});
          end
          stall_cnt = 0;
          req_seen  = 1'b0;
        end
      end
    end
  endtask

  // Presents one access in the cycle after the call and acts as the bus until done.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] sz, input logic sg, input int gd, input int rd,
                           input logic [31:0] rword, input logic [3:0] ebe,
                           input logic [31:0] eaddr, input logic [31:0] ewd,
                           input logic [31:0] erd, input logic emis);
    exp_t e;
    int   gcnt = 0;
    int   wcnt = 0;
    logic got = 1'b0;
    @(posedge clk); #1;
    if (!we && !emis) model_rdata = erd;
    e.we = we; e.addr = eaddr; e.be = ebe; e.wdata = ewd; e.rdata = model_rdata;
    e.mis = emis;
    e.stall = emis ? 1 : (2 + gd + (we ? 0 : rd));
    sb.push_back(e);
    req_valid = 1'b1; req_write = we; req_addr = addr; req_wdata = wd;
    req_size = sz; req_sign = sg;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk); #1;
      if (done) begin
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        got = 1'b1;
        break;
      end
      bus_rdata = rword;
      if (bus_req) begin
        gcnt++;
        bus_gnt    = (gcnt > gd);
        bus_rvalid = bus_gnt && !we && (rd == 0);
      end else begin
        bus_gnt    = 1'b0;
        wcnt++;
        bus_rvalid = (wcnt >= rd);
      end
    end
    if (!got) check_eq("access_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 3'b000; req_sign = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", {31'h0, stall}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_misalign", {31'h0, misalign}, 32'h0);
    check_eq("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check_eq("rst_bus_we", {31'h0, bus_we}, 32'h0);
    check_eq("rst_bus_addr", bus_addr, 32'h0);
    check_eq("rst_bus_be", {28'h0, bus_be}, 32'h0);
    check_eq("rst_bus_wdata", bus_wdata, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    //        we    addr        wdata        sz      sg   gd rd rword        be       eaddr       ewdata       erdata       mis
    do_access(1'b1, 32'h103, 32'h000000AB, 3'b000, 1'b0, 0, 0, 32'h0,        4'b1000, 32'h100, 32'hABABABAB, 32'h0,        1'b0);
    do_access(1'b0, 32'h202, 32'h0,        3'b001, 1'b1, 0, 1, 32'h80010000, 4'b1100, 32'h200, 32'h0,        32'hFFFF8001, 1'b0);
    do_access(1'b0, 32'h001, 32'h0,        3'b000, 1'b0, 0, 0, 32'h0000F200, 4'b0010, 32'h000, 32'h0,        32'h000000F2, 1'b0);
    do_access(1'b1, 32'h040, 32'h12345678, 3'b010, 1'b0, 4, 0, 32'h0,        4'b1111, 32'h040, 32'h12345678, 32'h0,        1'b0);
    do_access(1'b1, 32'h02E, 32'hCAFEBEEF, 3'b001, 1'b0, 0, 0, 32'h0,        4'b1100, 32'h02C, 32'hBEEFBEEF, 32'h0,        1'b0);
    do_access(1'b0, 32'h013, 32'h0,        3'b000, 1'b1, 1, 1, 32'h85000000, 4'b1000, 32'h010, 32'h0,        32'hFFFFFF85, 1'b0);
    do_access(1'b0, 32'h010, 32'h0,        3'b001, 1'b0, 0, 2, 32'h1234ABCD, 4'b0011, 32'h010, 32'h0,        32'h0000ABCD, 1'b0);
    do_access(1'b0, 32'h004, 32'h0,        3'b001, 1'b1, 0, 0, 32'h00007FFF, 4'b0011, 32'h004, 32'h0,        32'h00007FFF, 1'b0);
    do_access(1'b0, 32'h020, 32'h0,        3'b111, 1'b1, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h020, 32'h0,        32'hDEADBEEF, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
    do_access(1'b0, 32'h006, 32'h0,        3'b010, 1'b0, 0, 0, 32'h11223344, 4'b1111, 32'h004, 32'h0,        32'h0,        1'b1);
    do_access(1'b1, 32'h00B, 32'h0000BEEF, 3'b001, 1'b0, 0, 0, 32'h0,        4'b1100, 32'h008, 32'hBEEFBEEF, 32'h0,        1'b1);
`else
    do_access(1'b0, 32'h006, 32'h0,        3'b010, 1'b0, 0, 0, 32'h11223344, 4'b1111, 32'h004, 32'h0,        32'h11223344, 1'b0);
    do_access(1'b1, 32'h00B, 32'h0000BEEF, 3'b001, 1'b0, 0, 0, 32'h0,        4'b1100, 32'h008, 32'hBEEFBEEF, 32'h0,        1'b0);
`endif
    do_access(1'b0, 32'h00A, 32'h0,        3'b001, 1'b0, 2, 1, 32'hBEEF0000, 4'b1100, 32'h008, 32'h0,        32'h0000BEEF, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // Reset while waiting for read data; the late rvalid must be discarded.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50; req_size = 3'b010; req_sign = 1'b0;
    bus_gnt = 1'b1; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_test_req", {31'h0, bus_req}, 32'h1);
    @(posedge clk); #1;
    check_eq("rst_test_wait_stall", {31'h0, stall}, 32'h1);
    check_eq("rst_test_wait_noreq", {31'h0, bus_req}, 32'h0);
    bus_gnt = 1'b0; req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", {31'h0, done}, 32'h0);
      check_eq("post_rst_rdata", rdata, 32'h0);
      check_eq("post_rst_stall", {31'h0, stall}, 32'h0);
      check_eq("post_rst_bus_req", {31'h0, bus_req}, 32'h0);
    end
    check_eq("sb_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
